// File: rtl/axi_delay_pkg.sv
// Shared types and field helpers for the per-bank AXI address-channel delay model.
// State encoding, transaction classes, and address-field / delay-range helpers.
package axi_delay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_ACTIVE    = 2'd2,
      ST_REFRESH   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_HIT      = 2'd0,
      CLS_MISS     = 2'd1,
      CLS_CONFLICT = 2'd2
   } cls_t;

   function automatic int row_lsb(input int page_off, input int bank_w);
      return page_off + bank_w;
   endfunction

   function automatic int row_width(input int addr_w, input int page_off, input int bank_w);
      return addr_w - page_off - bank_w;
   endfunction

   function automatic int max_delay(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/axi_delay_bank_table.sv
// Per-bank open-row table: combinational hit/miss/conflict lookup, single write port
// and a clear-all used when a refresh closes every bank.
module axi_delay_bank_table
   import axi_delay_pkg::*;
#(
   parameter int BANK_WIDTH = 2,
   parameter int ROW_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_all,
   input  logic                  wr_en,
   input  logic [BANK_WIDTH-1:0] bank,
   input  logic [ROW_WIDTH-1:0]  row,
   output cls_t                  cls
);

   localparam int NUM_BANKS = 1 << BANK_WIDTH;

   logic [NUM_BANKS-1:0] open_vld_r;
   logic [ROW_WIDTH-1:0] open_row_r [NUM_BANKS];

   // Classify the addressed bank against its currently open row.
   always_comb begin
      cls = CLS_CONFLICT;
      if (!open_vld_r[bank]) begin
         cls = CLS_MISS;
      end else if (open_row_r[bank] == row) begin
         cls = CLS_HIT;
      end else begin
         cls = CLS_CONFLICT;
      end
   end

   // Open-row storage; clear-all only drops the valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         open_vld_r <= '0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            open_row_r[i] <= '0;
         end
      end else if (clr_all) begin
         open_vld_r <= '0;
      end else if (wr_en) begin
         open_vld_r[bank] <= 1'b1;
         open_row_r[bank] <= row;
      end
   end

endmodule

// File: rtl/axi_bank_delay.sv
// DRAM-timing model for one AXI address channel: gates VALID/READY for a latency picked
// per bank (hit/miss/conflict) and inserts a periodic refresh that closes all banks.
module axi_bank_delay
   import axi_delay_pkg::*;
#(
   parameter int ADDR_WIDTH        = 16,
   parameter int PAGE_OFFSET_WIDTH = 6,
   parameter int BANK_WIDTH        = 2,
   parameter int DELAY_WIDTH       = 5,
   parameter int HIT_DELAY         = 5,
   parameter int MISS_DELAY        = 12,
   parameter int CONFLICT_DELAY    = 16,
   parameter int REFRESH_PERIOD    = 0,
   parameter int REFRESH_WIDTH     = 10,
   parameter int REFRESH_DELAY     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   output logic                  out_valid,
   output logic                  out_ready,
   output logic                  evt_hit,
   output logic                  evt_miss,
   output logic                  evt_conflict,
   output logic                  refresh_busy
);

   localparam int ROW_WIDTH = row_width(ADDR_WIDTH, PAGE_OFFSET_WIDTH, BANK_WIDTH);
   localparam int ROW_LSB   = row_lsb(PAGE_OFFSET_WIDTH, BANK_WIDTH);
   localparam int MAX_DLY   = max_delay(HIT_DELAY, MISS_DELAY, CONFLICT_DELAY, REFRESH_DELAY);

   if (MAX_DLY > ((1 << DELAY_WIDTH) - 1)) begin : g_bad_delay_width
      $error("DELAY_WIDTH too narrow for the configured delays");
   end
   if (ROW_WIDTH < 1) begin : g_bad_row_width
      $error("address leaves no row bits above the bank field");
   end

   state_t                  state_r, state_nxt_s;
   logic [DELAY_WIDTH-1:0]  count_r, count_nxt_s, delay_s;
   logic                    evt_hit_r, evt_miss_r, evt_conflict_r;
   logic                    evt_hit_s, evt_miss_s, evt_conflict_s;
   logic                    wr_en_s, clr_all_s, refresh_done_s, refresh_pending_s;
   logic [BANK_WIDTH-1:0]   bank_s;
   logic [ROW_WIDTH-1:0]    row_s;
   logic                    unused_offset_s;
   cls_t                    cls_s;

   assign bank_s          = in_addr[PAGE_OFFSET_WIDTH +: BANK_WIDTH];
   assign row_s           = in_addr[ROW_LSB +: ROW_WIDTH];
   assign unused_offset_s = ^in_addr[PAGE_OFFSET_WIDTH-1:0];

   axi_delay_bank_table #(
      .BANK_WIDTH (BANK_WIDTH),
      .ROW_WIDTH  (ROW_WIDTH)
   ) u_bank_table (
      .clk     (clk),
      .rst     (rst),
      .clr_all (clr_all_s),
      .wr_en   (wr_en_s),
      .bank    (bank_s),
      .row     (row_s),
      .cls     (cls_s)
   );

   if (REFRESH_PERIOD > 0) begin : g_refresh
      logic [REFRESH_WIDTH-1:0] timer_r;
      logic                     pending_r;
      logic                     wrap_s;

      // A wrap in the same cycle counts as pending so refresh can start right away.
      assign wrap_s            = (timer_r == REFRESH_WIDTH'(REFRESH_PERIOD - 1));
      assign refresh_pending_s = pending_r | wrap_s;

      // Free-running interval timer and sticky pending flag.
      always_ff @(posedge clk) begin
         if (rst) begin
            timer_r   <= '0;
            pending_r <= 1'b0;
         end else begin
            timer_r <= wrap_s ? '0 : timer_r + REFRESH_WIDTH'(1);
            if (refresh_done_s) begin
               pending_r <= 1'b0;
            end else if (wrap_s) begin
               pending_r <= 1'b1;
            end
         end
      end
   end else begin : g_no_refresh
      logic unused_refresh_s;
      assign refresh_pending_s = 1'b0;
      assign unused_refresh_s  = refresh_done_s;
   end

   // Next-state, countdown load and classification events.
   always_comb begin
      state_nxt_s    = state_r;
      count_nxt_s    = count_r;
      delay_s        = '0;
      wr_en_s        = 1'b0;
      clr_all_s      = 1'b0;
      refresh_done_s = 1'b0;
      evt_hit_s      = 1'b0;
      evt_miss_s     = 1'b0;
      evt_conflict_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (refresh_pending_s) begin
               state_nxt_s = ST_REFRESH;
               count_nxt_s = DELAY_WIDTH'(REFRESH_DELAY);
            end else if (in_valid) begin
               wr_en_s = 1'b1;
               case (cls_s)
                  CLS_HIT: begin
                     evt_hit_s = 1'b1;
                     delay_s   = DELAY_WIDTH'(HIT_DELAY);
                  end
                  CLS_MISS: begin
                     evt_miss_s = 1'b1;
                     delay_s    = DELAY_WIDTH'(MISS_DELAY);
                  end
                  default: begin
                     evt_conflict_s = 1'b1;
                     delay_s        = DELAY_WIDTH'(CONFLICT_DELAY);
                  end
               endcase
               if (delay_s == '0) begin
                  state_nxt_s = ST_ACTIVE;
               end else begin
                  state_nxt_s = ST_COUNTDOWN;
                  count_nxt_s = delay_s;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COUNTDOWN: begin
            if (count_r <= DELAY_WIDTH'(1)) begin
               state_nxt_s = ST_ACTIVE;
            end else begin
               count_nxt_s = count_r - DELAY_WIDTH'(1);
            end
         end
         ST_ACTIVE: begin
            if (in_valid && in_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         ST_REFRESH: begin
            if (count_r <= DELAY_WIDTH'(1)) begin
               clr_all_s      = 1'b1;
               refresh_done_s = 1'b1;
               state_nxt_s    = ST_IDLE;
            end else begin
               count_nxt_s = count_r - DELAY_WIDTH'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, countdown and event pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         count_r        <= '0;
         evt_hit_r      <= 1'b0;
         evt_miss_r     <= 1'b0;
         evt_conflict_r <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         count_r        <= count_nxt_s;
         evt_hit_r      <= evt_hit_s;
         evt_miss_r     <= evt_miss_s;
         evt_conflict_r <= evt_conflict_s;
      end
   end

   assign out_valid    = (state_r == ST_ACTIVE) && in_valid;
   assign out_ready    = (state_r == ST_ACTIVE) && in_ready;
   assign refresh_busy = (state_r == ST_REFRESH);
   assign evt_hit      = evt_hit_r;
   assign evt_miss     = evt_miss_r;
   assign evt_conflict = evt_conflict_r;

endmodule

// File: tb/tb_axi_bank_delay.sv
// Bench for axi_bank_delay: randomized scoreboard on a refresh-less instance, plus
// cycle-exact refresh scenarios on a second instance with a 64-cycle refresh period.
module tb_axi_bank_delay;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready;
   logic [15:0] in_addr;
   logic        out_valid, out_ready, evt_hit, evt_miss, evt_conflict, refresh_busy;

   logic        rf_rst, rf_valid, rf_ready;
   logic [15:0] rf_addr;
   logic        rf_out_valid, rf_out_ready, rf_evt_hit, rf_evt_miss, rf_evt_conflict, rf_busy;

   axi_bank_delay u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready), .evt_hit(evt_hit), .evt_miss(evt_miss),
      .evt_conflict(evt_conflict), .refresh_busy(refresh_busy)
   );

   axi_bank_delay #(.REFRESH_PERIOD(64), .REFRESH_DELAY(8)) u_rf (
      .clk(clk), .rst(rf_rst), .in_valid(rf_valid), .in_ready(rf_ready), .in_addr(rf_addr),
      .out_valid(rf_out_valid), .out_ready(rf_out_ready), .evt_hit(rf_evt_hit),
      .evt_miss(rf_evt_miss), .evt_conflict(rf_evt_conflict), .refresh_busy(rf_busy)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rf_cyc = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rf_cyc <= rf_rst ? 0 : rf_cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: 0=hit 1=miss 2=conflict; bank=addr[7:6], row=addr[15:8]
   typedef struct {
      int cls;
      int evt_cyc;
      int valid_cyc;
   } exp_t;

   exp_t exp_q[$];
   bit   m_vld[4];
   int   m_row[4];

   function automatic exp_t predict(input logic [15:0] a, input int t);
      exp_t e;
      int   b, r, d;
      b = int'(a[7:6]);
      r = int'(a[15:8]);
      if (!m_vld[b]) begin
         e.cls = 1; d = 12;
      end else if (m_row[b] == r) begin
         e.cls = 0; d = 5;
      end else begin
         e.cls = 2; d = 16;
      end
      m_vld[b]    = 1'b1;
      m_row[b]    = r;
      e.evt_cyc   = t + 1;
      e.valid_cyc = t + 1 + d;
      return e;
   endfunction

   // Monitor: pops an expectation at each event pulse and times the opening of the gate.
   exp_t cur;
   bit   cur_vld = 1'b0;
   bit   seen_valid = 1'b0;

   always @(negedge clk) begin
      int n_evt, got_cls;
      #2;
      if (rst) begin
         exp_q.delete();
         cur_vld = 1'b0;
      end else begin
         n_evt = int'(evt_hit) + int'(evt_miss) + int'(evt_conflict);
         if (n_evt != 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_evt", n_evt, 0);
            end else begin
               cur = exp_q.pop_front();
               got_cls = evt_hit ? 0 : (evt_miss ? 1 : 2);
               check("evt_onehot", n_evt, 1);
               check("evt_class", got_cls, cur.cls);
               check("evt_cycle", cyc, cur.evt_cyc);
               cur_vld    = 1'b1;
               seen_valid = 1'b0;
            end
         end
         if (out_ready && !out_valid) check("ready_gated", out_ready, 0);
         if (out_valid) begin
            if (!cur_vld) begin
               check("valid_without_txn", out_valid, 0);
            end else if (!seen_valid) begin
               seen_valid = 1'b1;
               check("first_valid_cycle", cyc, cur.valid_cyc);
               check("ready_pass", out_ready, in_ready);
            end
            if (out_ready) cur_vld = 1'b0;
         end
      end
   end

   task automatic issue(input logic [15:0] a);
      int n;
      in_valid = 1'b1;
      in_addr  = a;
      exp_q.push_back(predict(a, cyc));
      n = 0;
      forever begin
         in_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) break;
         n++;
         if (n > 100) begin
            check("handshake_timeout", n, 0);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_ready = 1'b0;
   endtask

   task automatic rf_until(input int c);
      while (rf_cyc < c) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [15:0] a;
      logic [7:0]  rows [3];
      rows[0] = 8'h12; rows[1] = 8'h34; rows[2] = 8'h56;
      rst = 1'b1; in_valid = 1'b0; in_ready = 1'b0; in_addr = '0;
      rf_rst = 1'b1; rf_valid = 1'b0; rf_ready = 1'b0; rf_addr = '0;
      repeat (3) @(negedge clk);
      in_valid = 1'b1; in_ready = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ready", out_ready, 0);
      check("rst_evts", {evt_hit, evt_miss, evt_conflict}, 0);
      check("rst_busy", refresh_busy, 0);
      in_valid = 1'b0; in_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Directed sequence: miss, hit, conflict, miss on another bank.
      issue(16'h1200);
      issue(16'h1210);
      issue(16'h3400);
      issue(16'h1240);

      for (int i = 0; i < 40; i++) begin
         a = {rows[$urandom_range(0, 2)], 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
         issue(a);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset in the middle of a hit countdown.
      issue(16'h7880);
      in_valid = 1'b1; in_addr = 16'h7880; in_ready = 1'b1;
      exp_q.push_back(predict(16'h7880, cyc));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int b = 0; b < 4; b++) m_vld[b] = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_ready", out_ready, 0);
      check("midrst_evts", {evt_hit, evt_miss, evt_conflict}, 0);
      check("midrst_busy", refresh_busy, 0);
      rst = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
      @(negedge clk);
      issue(16'h7880);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("no_open_txn", cur_vld, 0);

      // Refresh instance: cycle 0 is the first cycle after the reset edge.
      rf_rst = 1'b1;
      @(negedge clk);
      rf_rst = 1'b0;
      rf_until(5);
      rf_valid = 1'b1; rf_addr = 16'h1200; rf_ready = 1'b1;
      for (int c = 5; c <= 19; c++) begin
         rf_until(c);
         if (c == 19) rf_valid = 1'b0;
         #1;
         check("rf_pre_miss", rf_evt_miss, (c == 6));
         check("rf_pre_valid", rf_out_valid, (c == 18));
      end
      for (int c = 60; c <= 86; c++) begin
         rf_until(c);
         if (c == 66) begin rf_valid = 1'b1; rf_addr = 16'h1200; end
         if (c == 86) rf_valid = 1'b0;
         #1;
         check("rf_busy_window", rf_busy, (c >= 64 && c <= 71));
         check("rf_after_ref_miss", rf_evt_miss, (c == 73));
         check("rf_no_hit", rf_evt_hit | rf_evt_conflict, 0);
         check("rf_valid_after_ref", rf_out_valid, (c == 85));
      end
      for (int c = 100; c <= 155; c++) begin
         rf_until(c);
         if (c == 100) begin rf_valid = 1'b1; rf_addr = 16'h5640; rf_ready = 1'b0; end
         if (c == 130) rf_ready = 1'b1;
         if (c == 154) rf_valid = 1'b0;
         #1;
         check("rf_busy_deferred", rf_busy, (c >= 132 && c <= 139));
         check("rf_miss_deferred", rf_evt_miss, (c == 101 || c == 141));
         check("rf_no_hit2", rf_evt_hit | rf_evt_conflict, 0);
         check("rf_valid_deferred", rf_out_valid, ((c >= 113 && c <= 130) || c == 153));
         check("rf_ready_deferred", rf_out_ready, (((c >= 113 && c <= 130) || c == 153) && rf_ready));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
